// File: rtl/dma_mem_responder_pkg.sv
// Shared types for the DMA memory responder.
// Engine state encodings and default bus widths.
package dma_resp_pkg;

  localparam int DMA_DW = 32;
  localparam int DMA_AW = 10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ACTIVE,
    RD_DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACTIVE,
    WR_DONE
  } wr_state_t;

  typedef logic [DMA_AW:0]   count_t;
  typedef logic [DMA_AW-1:0] addr_t;

endpackage

// File: rtl/dma_mem_responder_if.sv
// DMA handshake bundle between a peripheral and the memory responder.
// Carries err only when DMA_RESP_ERR_EN is defined.
interface dma_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic                  rd_go;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   rd_size;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  rd_done;

  logic                  wr_go;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_size;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  wr_done;

`ifdef DMA_RESP_ERR_EN
  logic                  err;

  modport master (
    output rd_go, rd_addr, rd_size, rd_en,
    output wr_go, wr_addr, wr_size, wr_en, wr_data,
    input  rd_data, empty, rd_done,
    input  full, wr_done, err
  );

  modport slave (
    input  rd_go, rd_addr, rd_size, rd_en,
    input  wr_go, wr_addr, wr_size, wr_en, wr_data,
    output rd_data, empty, rd_done,
    output full, wr_done, err
  );
`else
  modport master (
    output rd_go, rd_addr, rd_size, rd_en,
    output wr_go, wr_addr, wr_size, wr_en, wr_data,
    input  rd_data, empty, rd_done,
    input  full, wr_done
  );

  modport slave (
    input  rd_go, rd_addr, rd_size, rd_en,
    input  wr_go, wr_addr, wr_size, wr_en, wr_data,
    output rd_data, empty, rd_done,
    output full, wr_done
  );
`endif

endinterface

// File: rtl/dma_mem_responder_fifo.sv
// Show-ahead FIFO with occupancy count; one per responder direction.
// Head word is presented on data_o, forced to zero while empty.
module dma_resp_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              data_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  // A pop frees the slot, so a push on full is taken alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/dma_mem_responder.sv
// Dual-port RAM responder serving independent DMA read/write bursts.
// Define DMA_RESP_ERR_EN to add the sticky protocol-error flag bus.err.
module dma_mem_responder
  import dma_resp_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DW,
  parameter int ADDR_WIDTH = DMA_AW,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  dma_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] ram_rd_q;

  rd_state_t             rd_st_q;
  logic [ADDR_WIDTH-1:0] rd_base_q;
  logic [ADDR_WIDTH:0]   rd_size_q;
  logic [ADDR_WIDTH:0]   rd_iss_q;
  logic [ADDR_WIDTH:0]   rd_pop_q;
  logic                  rd_vld_q;
  logic                  rd_done_q;
  logic [ADDR_WIDTH-1:0] rd_raddr;
  logic [CW:0]           rd_occ;
  logic                  rd_issue;
  logic                  rd_pop;
  logic                  rf_empty;
  logic                  rf_full_unused;
  logic [CW-1:0]         rf_cnt;

  wr_state_t             wr_st_q;
  logic [ADDR_WIDTH-1:0] wr_base_q;
  logic [ADDR_WIDTH:0]   wr_size_q;
  logic [ADDR_WIDTH:0]   wr_psh_q;
  logic [ADDR_WIDTH:0]   wr_cmt_q;
  logic                  wr_done_q;
  logic [ADDR_WIDTH-1:0] wr_waddr;
  logic                  wr_push;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] wf_data;
  logic                  wf_empty;
  logic                  wf_full;
  logic [CW-1:0]         wf_cnt_unused;

  // Words already in the FIFO plus the one in the RAM pipe reserve space.
  assign rd_occ   = {1'b0, rf_cnt} + {{CW{1'b0}}, rd_vld_q};
  assign rd_issue = (rd_st_q == RD_ACTIVE)
                 && (rd_iss_q < rd_size_q)
                 && (rd_occ < (CW+1)'(FIFO_DEPTH));
  assign rd_raddr = rd_base_q + rd_iss_q[ADDR_WIDTH-1:0];
  assign rd_pop   = bus.rd_en && !rf_empty;

  assign wr_push   = bus.wr_en && !wf_full
                  && (wr_st_q == WR_ACTIVE)
                  && (wr_psh_q < wr_size_q);
  assign wr_commit = !wf_empty;
  assign wr_waddr  = wr_base_q + wr_cmt_q[ADDR_WIDTH-1:0];

  assign bus.rd_done = rd_done_q;
  assign bus.wr_done = wr_done_q;
  assign bus.full    = wf_full;

  always_ff @(posedge clk) begin
    if (wr_commit) ram_q[wr_waddr] <= wf_data;
    if (rd_issue)  ram_rd_q <= ram_q[rd_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_st_q   <= RD_IDLE;
      rd_base_q <= '0;
      rd_size_q <= '0;
      rd_iss_q  <= '0;
      rd_pop_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) rd_iss_q <= rd_iss_q + 1'b1;
      if (rd_pop)   rd_pop_q <= rd_pop_q + 1'b1;
      unique case (rd_st_q)
        RD_IDLE, RD_DONE: begin
          if (bus.rd_go) begin
            rd_base_q <= bus.rd_addr;
            rd_size_q <= bus.rd_size;
            rd_iss_q  <= '0;
            rd_pop_q  <= '0;
            rd_done_q <= (bus.rd_size == '0);
            rd_st_q   <= (bus.rd_size == '0) ? RD_DONE : RD_ACTIVE;
          end
        end
        RD_ACTIVE: begin
          if (rd_pop && (rd_pop_q + 1'b1 == rd_size_q)) begin
            rd_st_q   <= RD_DONE;
            rd_done_q <= 1'b1;
          end
        end
        default: rd_st_q <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st_q   <= WR_IDLE;
      wr_base_q <= '0;
      wr_size_q <= '0;
      wr_psh_q  <= '0;
      wr_cmt_q  <= '0;
      wr_done_q <= 1'b0;
    end else begin
      if (wr_push)   wr_psh_q <= wr_psh_q + 1'b1;
      if (wr_commit) wr_cmt_q <= wr_cmt_q + 1'b1;
      unique case (wr_st_q)
        WR_IDLE, WR_DONE: begin
          if (bus.wr_go) begin
            wr_base_q <= bus.wr_addr;
            wr_size_q <= bus.wr_size;
            wr_psh_q  <= '0;
            wr_cmt_q  <= '0;
            wr_done_q <= (bus.wr_size == '0);
            wr_st_q   <= (bus.wr_size == '0) ? WR_DONE : WR_ACTIVE;
          end
        end
        WR_ACTIVE: begin
          if (wr_commit && (wr_cmt_q + 1'b1 == wr_size_q)) begin
            wr_st_q   <= WR_DONE;
            wr_done_q <= 1'b1;
          end
        end
        default: wr_st_q <= WR_IDLE;
      endcase
    end
  end

  dma_resp_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_vld_q),
    .data_i  (ram_rd_q),
    .pop_i   (bus.rd_en),
    .data_o  (bus.rd_data),
    .empty_o (rf_empty),
    .full_o  (rf_full_unused),
    .count_o (rf_cnt)
  );

  assign bus.empty = rf_empty;

  dma_resp_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_push),
    .data_i  (bus.wr_data),
    .pop_i   (wr_commit),
    .data_o  (wf_data),
    .empty_o (wf_empty),
    .full_o  (wf_full),
    .count_o (wf_cnt_unused)
  );

`ifdef DMA_RESP_ERR_EN
  logic err_q;
  logic err_ev;

  assign err_ev = (bus.rd_en && rf_empty)
               || (bus.wr_en && wf_full)
               || (bus.wr_en && (wr_st_q != WR_ACTIVE))
               || (bus.rd_go && (rd_st_q == RD_ACTIVE))
               || (bus.wr_go && (wr_st_q == WR_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (err_ev) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_dma_mem_responder.sv
// Randomised bench for dma_mem_responder against a burst-level memory model.
// Build with DMA_RESP_ERR_EN to also check the sticky err flag.
module tb_dma_mem_responder;
  import dma_resp_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int N     = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dma_mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory image, expected read stream, pending writes.
  logic [DW-1:0] mram [N];
  logic [DW-1:0] rq [$];
  int            pa [$];
  logic [DW-1:0] pd [$];
  int  cyc = 0;
  int  rd_go_cyc = -100;
  bit  rd_act_m, rd_done_m, wr_act_m, wr_done_m, err_m;
  int  rd_sz_m, rd_pop_m, wr_sz_m, wr_psh_m, wr_cmt_m, wr_base_m;

  always @(negedge clk) begin
    bit ra_old, wa_old, nerr, full_m;
    cyc++;
    if (!rst_n) begin
      chk("rst_rd_done", bus.rd_done, 0);
      chk("rst_wr_done", bus.wr_done, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_rd_data", bus.rd_data, 0);
`ifdef DMA_RESP_ERR_EN
      chk("rst_err", bus.err, 0);
`endif
      rq.delete(); pa.delete(); pd.delete();
      rd_act_m = 0; rd_done_m = 0; wr_act_m = 0; wr_done_m = 0;
      err_m = 0; rd_go_cyc = -100;
    end else begin
      full_m = (pa.size() == DEPTH);
      chk("rd_done", bus.rd_done, rd_done_m);
      chk("wr_done", bus.wr_done, wr_done_m);
      chk("full", bus.full, full_m);
`ifdef DMA_RESP_ERR_EN
      chk("err", bus.err, err_m);
`endif
      if (!bus.empty) begin
        if (rq.size() == 0) begin
          checks++; errs++;
          $display("FAIL spurious_word: empty=0 expected 1 at %0t", $time);
        end else chk("rd_data", bus.rd_data, rq[0]);
      end
      if (rd_act_m && (cyc == rd_go_cyc + 1 || cyc == rd_go_cyc + 2))
        chk("latency_empty", bus.empty, 1);
      if (rd_act_m && cyc == rd_go_cyc + 3)
        chk("first_word", bus.empty, 0);

      ra_old = rd_act_m;
      wa_old = wr_act_m;
      nerr = err_m || (bus.rd_en && bus.empty) || (bus.wr_en && full_m)
          || (bus.wr_en && !wa_old) || (bus.rd_go && ra_old)
          || (bus.wr_go && wa_old);
      if (pa.size() > 0) begin
        mram[pa[0]] = pd[0];
        void'(pa.pop_front()); void'(pd.pop_front());
        wr_cmt_m++;
        if (wr_cmt_m == wr_sz_m) begin wr_act_m = 0; wr_done_m = 1; end
      end
      if (bus.wr_en && wa_old && !full_m && wr_psh_m < wr_sz_m) begin
        pa.push_back((wr_base_m + wr_psh_m) % N);
        pd.push_back(bus.wr_data);
        wr_psh_m++;
      end
      if (bus.wr_go && !wa_old) begin
        wr_base_m = int'(bus.wr_addr); wr_sz_m = int'(bus.wr_size);
        wr_psh_m = 0; wr_cmt_m = 0;
        wr_act_m = (wr_sz_m != 0); wr_done_m = (wr_sz_m == 0);
      end
      if (bus.rd_en && !bus.empty && rq.size() > 0) begin
        void'(rq.pop_front());
        rd_pop_m++;
        if (rd_pop_m == rd_sz_m) begin rd_act_m = 0; rd_done_m = 1; end
      end
      if (bus.rd_go && !ra_old) begin
        rq.delete();
        rd_sz_m = int'(bus.rd_size);
        for (int i = 0; i < rd_sz_m; i++)
          rq.push_back(mram[(int'(bus.rd_addr) + i) % N]);
        rd_pop_m = 0;
        rd_act_m = (rd_sz_m != 0); rd_done_m = (rd_sz_m == 0);
        rd_go_cyc = cyc;
      end
      err_m = nerr;
    end
  end

  logic [DW-1:0] got [$];
  int first;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input int addr, input int size, input int pct,
                          input bit seq, input logic [DW-1:0] base);
    int i, t;
    bus.wr_go = 1'b1;
    bus.wr_addr = addr[AW-1:0];
    bus.wr_size = size[AW:0];
    tick();
    bus.wr_go = 1'b0;
    i = 0; t = 0;
    while (i < size && t < 4 * size + 20) begin
      bus.wr_en = ($urandom_range(99) < pct);
      bus.wr_data = seq ? base + DW'(i) : $urandom;
      @(negedge clk);
      if (bus.wr_en && !bus.full) i++;
      tick(); t++;
    end
    bus.wr_en = 1'b1;
    bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.wr_en = 1'b0;
    t = 0;
    while (!bus.wr_done && t < 20) begin tick(); t++; end
    chk("wr_done_wait", bus.wr_done, 1);
  endtask

  task automatic rd_burst(input int addr, input int size, input int pct,
                          output int fst);
    int n, t;
    got.delete();
    fst = -1;
    bus.rd_go = 1'b1;
    bus.rd_addr = addr[AW-1:0];
    bus.rd_size = size[AW:0];
    tick();
    bus.rd_go = 1'b0;
    n = 0; t = 0;
    while (n < size && t < 8 * size + 40) begin
      bus.rd_en = ($urandom_range(99) < pct);
      @(negedge clk);
      if (bus.rd_en && !bus.empty) begin
        got.push_back(bus.rd_data);
        if (fst < 0) fst = t;
        n++;
      end
      tick(); t++;
    end
    bus.rd_en = 1'b0;
    chk("rd_done_next", bus.rd_done, 1);
    chk("rd_count", got.size(), size);
  endtask

  task automatic chk_seq(input string nm, input int n, input logic [DW-1:0] b);
    for (int i = 0; i < n; i++)
      chk(nm, (i < got.size()) ? got[i] : 'x, b + DW'(i));
  endtask

  initial begin
    int ra, wa, sr, sw;
    bus.rd_go = 0; bus.rd_addr = 0; bus.rd_size = 0; bus.rd_en = 0;
    bus.wr_go = 0; bus.wr_addr = 0; bus.wr_size = 0; bus.wr_en = 0;
    bus.wr_data = 0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    bus.rd_go = 1; bus.wr_go = 1;
    @(negedge clk);
    chk("sz0_rd_done_pre", bus.rd_done, 0);
    chk("sz0_wr_done_pre", bus.wr_done, 0);
    tick();
    bus.rd_go = 0; bus.wr_go = 0;
    @(negedge clk);
    chk("sz0_rd_done", bus.rd_done, 1);
    chk("sz0_wr_done", bus.wr_done, 1);
    tick();

    wr_burst(0, N, 100, 0, 0);

    wr_burst(16, 16, 70, 1, 0);
    rd_burst(16, 16, 100, first);
    chk("first_pop_cycle", first, 2);
    chk_seq("wr_rd_0_15", 16, 0);
    @(negedge clk);
    chk("empty_after", bus.empty, 1);
    tick();

    bus.wr_en = 1; bus.wr_data = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    bus.wr_en = 0;
    bus.rd_en = 1;
    tick(); tick();
    bus.rd_en = 0;
    rd_burst(16, 4, 100, first);
    chk_seq("idle_wr_dropped", 4, 0);

    wr_burst(N - 4, 8, 80, 1, 32'hA0);
    rd_burst(0, 4, 100, first);
    chk_seq("wrap_low", 4, 32'hA4);
    rd_burst(N - 4, 8, 60, first);
    chk_seq("wrap_all", 8, 32'hA0);

    rd_burst($urandom_range(N - 1), 64, 50, first);

    bus.rd_go = 1; bus.rd_addr = 16; bus.rd_size = 32;
    tick();
    bus.rd_go = 0; bus.rd_en = 1;
    repeat (6) tick();
    rst_n = 0;
    @(negedge clk);
    chk("midrst_rd_done", bus.rd_done, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_rd_data", bus.rd_data, 0);
    tick();
    rst_n = 1; bus.rd_en = 0;
    tick();
`ifdef DMA_RESP_ERR_EN
    chk("err_clear", bus.err, 0);
`endif
    bus.rd_en = 1;
    tick();
    bus.rd_en = 0;
    @(negedge clk);
    chk("underflow_empty", bus.empty, 1);
`ifdef DMA_RESP_ERR_EN
    chk("err_set", bus.err, 1);
    tick(); tick();
    chk("err_sticky", bus.err, 1);
`endif
    rd_burst(16, 4, 100, first);
    chk_seq("after_reset", 4, 0);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom_range(N - 1);
      wa = (ra + N / 2) % N;
      sr = $urandom_range(1, 48);
      sw = $urandom_range(1, 48);
      fork
        wr_burst(wa, sw, $urandom_range(30, 100), 0, 0);
        rd_burst(ra, sr, $urandom_range(30, 100), first);
      join
      rd_burst(wa, sw, $urandom_range(30, 100), first);
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
